// File: rtl/vga_pixel_out.sv
// VGA pixel output stage: registers colour/sync/blank from the upstream pixel timer
// and feeds the colour path from a small prefetch FIFO filled by single-word memory reads.
module vga_pixel_out #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable,
  input  logic        pixel_tick,
  input  logic [9:0]  col_in,
  input  logic [9:0]  row_in,
  output logic        rd_req,
  output logic [19:0] rd_addr,
  input  logic        rd_ack,
  input  logic [23:0] rd_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        underflow
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [9:0]       H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0]       HS_START  = 10'd656;
  localparam logic [9:0]       HS_END    = 10'd751;
  localparam logic [9:0]       VS_START  = 10'd490;
  localparam logic [9:0]       VS_END    = 10'd491;
  localparam logic [9:0]       COL_LAST  = 10'd799;
  localparam logic [9:0]       ROW_LAST  = 10'd524;
  localparam logic [19:0]      PIX_LIMIT = 20'(H_VISIBLE * V_VISIBLE);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } req_state_t;

  req_state_t       r_state;
  req_state_t       w_state_nxt;
  logic             w_issue;
  logic             w_ack_ok;
  logic             w_upd;
  logic             w_visible;
  logic             w_frame_end;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [23:0]      w_head;
  logic             r_discard;
  logic [19:0]      r_pf_addr;
  logic [19:0]      r_rd_addr;
  logic [23:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic [7:0]       r_blue;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_blank;
  logic             r_underflow;

  assign w_upd       = pixel_tick & enable;
  assign w_visible   = (col_in < H_VIS) && (row_in < V_VIS);
  assign w_frame_end = w_upd && (col_in == COL_LAST) && (row_in == ROW_LAST);
  assign w_empty     = (r_count == CNT_ZERO);
  assign w_head      = r_mem[r_rd_ptr];
  // A restart flush wins over a same-cycle push; a request that straddled a restart is dropped.
  assign w_push      = w_ack_ok && !r_discard && !w_frame_end;
  assign w_pop       = w_upd && w_visible && !w_empty;

  // Request state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request next-state: one outstanding read, only while the FIFO has room for it.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_ack_ok    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && (r_pf_addr < PIX_LIMIT) && (r_count < DEPTH_C) && !w_frame_end) begin
          w_state_nxt = S_REQ;
          w_issue     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (rd_ack) begin
          w_state_nxt = S_IDLE;
          w_ack_ok    = 1'b1;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Prefetch address, latched request address and stale-request marker.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pf_addr <= 20'd0;
      r_rd_addr <= 20'd0;
      r_discard <= 1'b0;
    end else begin
      if (w_frame_end) begin
        r_pf_addr <= 20'd0;
      end else if (w_push) begin
        r_pf_addr <= r_pf_addr + 20'd1;
      end
      if (w_issue) begin
        r_rd_addr <= r_pf_addr;
      end
      if (w_ack_ok) begin
        r_discard <= 1'b0;
      end else if (w_frame_end && (r_state == S_REQ)) begin
        r_discard <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
    end else if (w_frame_end) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rd_data;
    end
  end

  // Registered pixel outputs, updated only on an enabled pixel tick.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_red       <= 8'd0;
      r_green     <= 8'd0;
      r_blue      <= 8'd0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_blank     <= 1'b1;
      r_underflow <= 1'b0;
    end else if (w_upd) begin
      r_blank <= !w_visible;
      r_hsync <= !((col_in >= HS_START) && (col_in <= HS_END));
      r_vsync <= !((row_in >= VS_START) && (row_in <= VS_END));
      if (w_pop) begin
        {r_red, r_green, r_blue} <= w_head;
      end else begin
        {r_red, r_green, r_blue} <= 24'd0;
      end
      if (w_visible && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign rd_req    = (r_state == S_REQ);
  assign rd_addr   = r_rd_addr;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign blank     = r_blank;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Bench for vga_pixel_out: directed scenarios then randomized traffic, checked against
// a queue-based model of the prefetch buffer and the sync/blank rules.
module tb_vga_pixel_out;

  logic        clk;
  logic        n_rst;
  logic        enable;
  logic        pixel_tick;
  logic [9:0]  col_in;
  logic [9:0]  row_in;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_ack;
  logic [23:0] rd_data;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        underflow;

  vga_pixel_out dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .pixel_tick(pixel_tick),
    .col_in(col_in), .row_in(row_in), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blank(blank), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_fail;
  int          n_total;
  logic [23:0] q[$];
  logic [23:0] script[$];
  logic [19:0] model_pf;
  logic        stale;
  int          n_accept;
  logic [23:0] exp_rgb;
  logic        exp_blank;
  logic        exp_hs;
  logic        exp_vs;
  logic        exp_uf;
  int          wait_cnt;
  int          ack_delay;
  logic        ack_mode;
  logic        spur_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    model_pf  = 20'd0;
    stale     = 1'b0;
    n_accept  = 0;
    exp_rgb   = 24'd0;
    exp_blank = 1'b1;
    exp_hs    = 1'b1;
    exp_vs    = 1'b1;
    exp_uf    = 1'b0;
    wait_cnt  = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb"}, {red, green, blue}, 24'd0);
    chk({tag, "_hsync"}, hsync, 1'b1);
    chk({tag, "_vsync"}, vsync, 1'b1);
    chk({tag, "_blank"}, blank, 1'b1);
    chk({tag, "_uf"}, underflow, 1'b0);
    chk({tag, "_rd_req"}, rd_req, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, 20'd0);
  endtask

  task automatic do_reset();
    n_rst      = 1'b0;
    rd_ack     = 1'b0;
    pixel_tick = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("reset");
    model_reset();
    n_rst = 1'b1;
  endtask

  // One clock: memory model drives the ack, then the reference model advances and outputs are checked.
  task automatic step();
    logic        req_p, ack_p, tick_p, en_p, vis, fend;
    logic [9:0]  c_p, r_p;
    logic [19:0] a_p;
    logic [23:0] d_p;
    rd_ack  = 1'b0;
    rd_data = 24'd0;
    if (rd_req && ack_mode && (wait_cnt >= ack_delay)) begin
      rd_ack = 1'b1;
      if (script.size() > 0) rd_data = script.pop_front();
      else rd_data = 24'($urandom);
    end else if (!rd_req && spur_en && ($urandom_range(0, 7) == 0)) begin
      rd_ack  = 1'b1;
      rd_data = 24'($urandom);
    end
    req_p = rd_req; ack_p = rd_ack; tick_p = pixel_tick; en_p = enable;
    c_p = col_in; r_p = row_in; a_p = rd_addr; d_p = rd_data;
    @(posedge clk);
    #1;
    rd_ack     = 1'b0;
    pixel_tick = 1'b0;
    if (tick_p && en_p) begin
      vis       = (c_p < 10'd640) && (r_p < 10'd480);
      exp_blank = !vis;
      exp_hs    = !((c_p >= 10'd656) && (c_p <= 10'd751));
      exp_vs    = !((r_p >= 10'd490) && (r_p <= 10'd491));
      if (!vis) exp_rgb = 24'd0;
      else if (q.size() > 0) exp_rgb = q.pop_front();
      else begin
        exp_rgb = 24'd0;
        exp_uf  = 1'b1;
      end
    end
    fend = tick_p && en_p && (c_p == 10'd799) && (r_p == 10'd524);
    if (req_p && ack_p) begin
      if (!stale && !fend) begin
        chk("ack_addr", a_p, model_pf);
        q.push_back(d_p);
        model_pf = model_pf + 20'd1;
        n_accept++;
      end
      stale = 1'b0;
    end
    if (fend) begin
      q.delete();
      model_pf = 20'd0;
      if (req_p && !ack_p) stale = 1'b1;
    end
    if (rd_req) wait_cnt++;
    else wait_cnt = 0;
    chk("rgb", {red, green, blue}, exp_rgb);
    chk("blank", blank, exp_blank);
    chk("hsync", hsync, exp_hs);
    chk("vsync", vsync, exp_vs);
    chk("underflow", underflow, exp_uf);
    chk("req_when_full", (rd_req && (q.size() >= 4)), 1'b0);
  endtask

  task automatic tick_at(input logic [9:0] c, input logic [9:0] r);
    pixel_tick = 1'b1;
    col_in     = c;
    row_in     = r;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    n_pass = 0; n_fail = 0; n_total = 0;
    n_rst = 1'b1; enable = 1'b0; pixel_tick = 1'b0; col_in = 10'd0; row_in = 10'd0;
    rd_ack = 1'b0; rd_data = 24'd0;
    ack_mode = 1'b1; ack_delay = 2; spur_en = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Fill: addresses 0..3, then no request while full.
    enable = 1'b1;
    script.push_back(24'hAA5501);
    for (int i = 0; i < 30; i++) step();
    chk("fill_accepts", n_accept, 4);
    chk("full_no_req", rd_req, 1'b0);

    // First visible pixel comes from the FIFO head.
    tick_at(10'd0, 10'd0);
    chk("px_red", red, 8'hAA);
    chk("px_green", green, 8'h55);
    chk("px_blue", blue, 8'h01);
    chk("px_blank", blank, 1'b0);
    chk("px_hsync", hsync, 1'b1);
    chk("px_vsync", vsync, 1'b1);

    // Horizontal and vertical sync edges.
    tick_at(10'd655, 10'd10); chk("hs655", hsync, 1'b1); chk("bl655", blank, 1'b1);
    tick_at(10'd656, 10'd10); chk("hs656", hsync, 1'b0); chk("bl656", blank, 1'b1);
    tick_at(10'd751, 10'd10); chk("hs751", hsync, 1'b0); chk("bl751", blank, 1'b1);
    tick_at(10'd752, 10'd10); chk("hs752", hsync, 1'b1); chk("bl752", blank, 1'b1);
    tick_at(10'd0, 10'd490);  chk("vs490", vsync, 1'b0);
    tick_at(10'd0, 10'd491);  chk("vs491", vsync, 1'b0);
    tick_at(10'd0, 10'd492);  chk("vs492", vsync, 1'b1);

    // Disabled tick holds outputs.
    enable = 1'b0;
    tick_at(10'd5, 10'd5);
    chk("hold_vsync", vsync, 1'b1);
    enable = 1'b1;

    // Underflow is sticky until reset.
    do_reset();
    ack_mode = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tick_at(10'd5, 10'd5);
    chk("uf_set", underflow, 1'b1);
    chk("uf_rgb", {red, green, blue}, 24'd0);
    ack_mode = 1'b1;
    for (int i = 0; i < 12; i++) step();
    tick_at(10'd6, 10'd5);
    chk("uf_sticky", underflow, 1'b1);
    do_reset();

    // Frame restart with a request pending.
    ack_delay = 3;
    for (int i = 0; i < 40; i++) begin
      if ((n_accept >= 2) && rd_req && (wait_cnt == 1)) break;
      step();
    end
    chk("fr_pending", rd_req, 1'b1);
    tick_at(10'd799, 10'd524);
    tick_at(10'd0, 10'd0);
    chk("fr_flushed_uf", underflow, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (!stale && rd_req) break;
      step();
    end
    chk("fr_next_req", rd_req, 1'b1);
    chk("fr_next_addr", rd_addr, 20'd0);
    for (int i = 0; i < 8; i++) step();

    // Reset mid-request with three entries buffered.
    do_reset();
    ack_delay = 2;
    for (int i = 0; i < 20; i++) begin
      if (n_accept >= 1) break;
      step();
    end
    tick_at(10'd0, 10'd0);
    for (int i = 0; i < 40; i++) begin
      if ((q.size() == 3) && rd_req) break;
      step();
    end
    chk("mid_req", rd_req, 1'b1);
    chk("mid_blank", blank, 1'b0);
    n_rst = 1'b0;
    #1;
    chk_reset("async_rst");
    rd_ack  = 1'b1;
    rd_data = 24'h123456;
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    chk("rst_ack_req", rd_req, 1'b0);
    model_reset();
    n_rst    = 1'b1;
    ack_mode = 1'b0;
    tick_at(10'd1, 10'd1);
    chk("rst_ack_nopush", underflow, 1'b1);

    // Randomized traffic.
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      ack_mode  = ($urandom_range(0, 7) != 0);
      ack_delay = $urandom_range(1, 4);
      pixel_tick = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      if (r < 60) begin
        col_in = 10'($urandom_range(0, 639));
        row_in = 10'($urandom_range(0, 479));
      end else if (r < 90) begin
        col_in = 10'($urandom_range(0, 799));
        row_in = 10'($urandom_range(0, 524));
      end else if (r < 95) begin
        col_in = 10'd799;
        row_in = 10'd524;
      end else begin
        col_in = 10'($urandom_range(638, 658));
        row_in = 10'($urandom_range(478, 493));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_pixel_out.md
VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

Interface
REQ-001 Parameter H_VISIBLE, 640, visible columns per line; the horizontal total is fixed at 800.
REQ-002 Parameter V_VISIBLE, 480, visible rows per frame; the vertical total is fixed at 525.
REQ-003 Parameter FIFO_DEPTH, 4, number of prefetch buffer entries; SHALL be a power of 2 and at least 2.
REQ-004 Port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port n_rst, input, 1, reset; asynchronous and active-low.
REQ-006 Port enable, input, 1, when low, no pixel processing and no new memory requests.
REQ-007 Port pixel_tick, input, 1, one-clk strobe per pixel period from the upstream timer.
REQ-008 Port col_in, input, 10, current column from the upstream timer (0..799).
REQ-009 Port row_in, input, 10, current row from the upstream timer (0..524).
REQ-010 Port rd_req, output, 1, memory read request.
REQ-011 Port rd_addr, output, 20, pixel address being requested.
REQ-012 Port rd_ack, input, 1, one-clk acknowledge; rd_data is valid in the same cycle.
REQ-013 Port rd_data, input, 24, pixel word laid out as {R[23:16], G[15:8], B[7:0]}.
REQ-014 Port red/green/blue, output, 8 each, registered colour outputs.
REQ-015 Port hsync/vsync, output, 1 each, active-low sync outputs.
REQ-016 Port blank, output, 1, high when the current pixel is outside the visible area.
REQ-017 Port underflow, output, 1, sticky flag for a FIFO-empty event during the visible area.

Function
REQ-018 All outputs SHALL update only on a clk edge where pixel_tick=1 and enable=1, giving one-clk latency from the sampled col_in/row_in; outputs SHALL hold otherwise.
REQ-019 On an update, blank SHALL be set to 1 unless col_in<H_VISIBLE and row_in<V_VISIBLE.
REQ-020 hsync SHALL be 0 for col_in in 656..751 inclusive and 1 otherwise.
REQ-021 vsync SHALL be 0 for row_in in 490..491 inclusive and 1 otherwise.
REQ-022 On a visible update, the block SHALL pop the FIFO head onto red/green/blue.
REQ-023 On a visible update with the FIFO empty, red/green/blue SHALL be set to 0 and underflow SHALL be set to 1.
REQ-024 On a blanked update, red/green/blue SHALL be set to 0 and no pop SHALL occur.
REQ-025 Prefetch address counter pf_addr (20 bits) SHALL run from 0 to H_VISIBLE*V_VISIBLE-1 (307199 at default parameters).
- pf_addr increments once per accepted rd_ack.
- pf_addr saturates at H_VISIBLE*V_VISIBLE and issues no further requests.
REQ-026 Frame restart: on an update with col_in=799 and row_in=524, pf_addr SHALL be cleared to 0 and the FIFO flushed.
- The flush overrides any same-cycle push.
- An outstanding request SHALL be allowed to complete, and its data discarded.
REQ-027 Request state machine:
- IDLE -> REQ when enable=1, pf_addr<limit, and FIFO count<FIFO_DEPTH.
- REQ holds rd_req=1 with rd_addr=pf_addr stable.
- REQ -> IDLE on rd_ack, pushing rd_data into the FIFO.
- At most one request SHALL be outstanding at a time.
REQ-028 rd_req SHALL remain asserted in REQ until rd_ack even if enable falls.
REQ-029 A same-cycle push and pop SHALL leave the FIFO count unchanged, with the popped data being the old head.
REQ-030 A push into a full FIFO SHALL be impossible by construction.
REQ-031 rd_ack received in IDLE SHALL be ignored.

Reset
REQ-032 While n_rst=0, the block SHALL hold:
- red/green/blue=0, hsync=1, vsync=1, blank=1, underflow=0;
- rd_req=0, rd_addr=0, pf_addr=0;
- FIFO empty, request state machine in IDLE.
REQ-033 A reset asserted mid-request SHALL drop rd_req asynchronously; a later rd_ack SHALL be ignored.

Verification
REQ-034 Scenario: reset, then enable=1 with a memory model that acks 2 clks after req -> rd_addr sequence 0,1,2,3 with a 4th push, then rd_req stays low with FIFO full.
REQ-035 Scenario: tick at col=0, row=0 with FIFO holding 0xAA5501 -> next clk red=AA, green=55, blue=01, blank=0, hsync=1, vsync=1.
REQ-036 Scenario: ticks at col=655/656/751/752 on row 10 -> hsync 1/0/0/1 and blank=1 for all four; at row=490/491/492 -> vsync 0/0/1.
REQ-037 Scenario: memory never acks, visible tick -> rgb=0, underflow=1, and underflow remains 1 through later good pixels until reset.
REQ-038 Scenario: tick at col=799, row=524 while rd_req is pending -> FIFO empties, the pending ack data is dropped, and the next rd_addr is 0.
REQ-039 Scenario: n_rst pulled low while rd_req=1 and FIFO has 3 entries -> all outputs take REQ-032 values immediately, and an ack during reset causes no push.
